atmega_spi_burst_m: RTL
=======================

// Module: atmega_spi_burst_m
// PURPOSE
//   Burst sequencer sitting directly upstream of the ATmega-style SPI master (SPCR/SPSR/SPDR register block).
//   Acts as bus master on that block's register port: configures it, feeds bytes from a TX FIFO into SPDR,
//   polls SPIF in SPSR, and collects received bytes from SPDR into an RX FIFO. Frees the CPU from byte-level polling.
// PARAMETERS
//   BUS_ADDR_DATA_LEN  8      width of spi_addr_o
//   SPCR_ADDR          'h20   SPI control register address
//   SPSR_ADDR          'h21   SPI status register address
//   SPDR_ADDR          'h22   SPI data register address
//   FIFO_DEPTH         16     entries per TX/RX FIFO; power of two, >=2
//   TIMEOUT_CYCLES     4096   POLL watchdog limit (used only with ATMEGA_SPI_BURST_TIMEOUT_EN)
// PORTS
//   clk_i        in   1   clock
//   rst_ni       in   1   asynchronous active-low reset
//   start_i      in   1   begin burst (ignored while busy_o=1)
//   len_i        in   8   burst length in bytes; 0 means 256, sampled at start_i
//   cfg_i        in   8   SPCR image; EN(6) and MSTR(4) forced to 1, SPIE(7) forced to 0
//   busy_o       out  1   burst in progress
//   done_o       out  1   one-cycle pulse at burst end
//   err_o        out  1   sticky timeout flag, cleared by start_i (timeout build only, else tied 0)
//   tx_data_i    in   8   TX FIFO write data
//   tx_valid_i   in   1   TX push request
//   tx_ready_o   out  1   TX FIFO not full
//   rx_data_o    out  8   RX FIFO head
//   rx_valid_o   out  1   RX FIFO not empty
//   rx_ready_i   in   1   RX pop
//   spi_addr_o   out  BUS_ADDR_DATA_LEN  register address to SPI master
//   spi_wr_o     out  1   register write strobe
//   spi_rd_o     out  1   register read strobe (SPI read data is combinational, sampled same cycle)
//   spi_bus_o    out  8   write data
//   spi_bus_i    in   8   read data
// BEHAVIOUR
//   Reset: state IDLE; FIFOs empty; busy_o, done_o, err_o, spi_wr_o, spi_rd_o = 0; spi_addr_o, spi_bus_o = 0.
//   Handshakes: TX push when tx_valid_i & tx_ready_o; RX pop when rx_valid_o & rx_ready_i; push+pop same cycle legal on either FIFO.
//   FSM, one register access per cycle:
//     IDLE : start_i -> CFG; latch remaining = (len_i==0) ? 256 : len_i (9-bit counter); busy_o=1 from next cycle.
//     CFG  : spi_wr_o=1 @SPCR, data = (cfg_i | 8'h50) & 8'h7F -> CLR.
//     CLR  : spi_rd_o=1 @SPSR (read clears any stale SPIF); result discarded -> LOAD.
//     LOAD : TX empty -> stay, no strobe. Else spi_wr_o=1 @SPDR, data = TX head, pop TX -> POLL.
//     POLL : spi_rd_o=1 @SPSR every cycle; spi_bus_i[7]=1 -> READ, else stay.
//     READ : RX full -> stay, no strobe (SPDR holds data). Else spi_rd_o=1 @SPDR, push spi_bus_i,
//            remaining-1; remaining was 1 -> DONE, else LOAD.
//     DONE : done_o=1 for one cycle, busy_o=0 -> IDLE.
//   Byte latency is 1 (LOAD) + SPI transfer + SPIF set + 1 (POLL hit) + 1 (READ).
//   start_i while busy: ignored. TX FIFO may be pre-filled in IDLE; leftover TX bytes persist after DONE.
//   Reset mid-burst: all state cleared immediately; the SPI master may finish its in-flight byte, and its stale SPIF is cleared by the next burst's CLR.
// CONFIGURATION
//   `ATMEGA_SPI_BURST_TIMEOUT_EN defined: 13-bit counter cleared on entry to POLL, increments each POLL cycle;
//     reaching TIMEOUT_CYCLES -> err_o=1, flush TX FIFO -> DONE (done_o still pulses). RX keeps bytes already received.
//   Undefined: no counter; POLL waits indefinitely; err_o tied 0.
// STRUCTURE
//   Shared header atmega_spi_pkg: SPCR/SPSR bit positions (EN, MSTR, SPIE, SPIF) and FSM state encodings
//     (IDLE, CFG, CLR, LOAD, POLL, READ, DONE).
//   One sub-module: atmega_spi_burst_fifo (8-bit synchronous FIFO, depth FIFO_DEPTH, full/empty, async active-low reset),
//     instantiated twice (TX, RX).
// TESTING (bench pairs DUT with the real SPI master, MISO looped to MOSI)
//   Prefill TX 8'hA5,8'h3C; len_i=2, cfg_i=0 -> SPCR write 8'h50; RX = A5,3C; done_o one pulse; busy_o low afterwards.
//   len_i=0 with 256 bytes streamed into TX -> exactly 256 RX bytes, done_o once.
//   len_i=3 with TX empty for 100 cycles -> no SPDR write; FSM holds LOAD; resumes on push.
//   RX held full (rx_ready_i=0, FIFO_DEPTH=16, len_i=20) -> READ stalls, no SPDR read; releasing rx_ready_i drains all 20 bytes in order.
//   Assert rst_ni low while in POLL -> all outputs 0 next edge; new burst len_i=1 completes correctly.
//   Timeout build, MISO/SCK path gated so SPIF never sets -> err_o=1 after 4096 POLL cycles, done_o pulse, TX empty.

Source files
------------

// File: rtl/atmega_spi_pkg.sv
// Shared definitions for the ATmega SPI burst sequencer: SPCR/SPSR bit
// positions, FSM state encoding and the SPCR image helper.
package atmega_spi_pkg;

  localparam int unsigned SPCR_SPIE = 7;
  localparam int unsigned SPCR_EN   = 6;
  localparam int unsigned SPCR_MSTR = 4;
  localparam int unsigned SPSR_SPIF = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_CLR  = 3'd2,
    ST_LOAD = 3'd3,
    ST_POLL = 3'd4,
    ST_READ = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Master mode enabled, interrupt masked: the sequencer polls SPIF itself.
  function automatic logic [7:0] spcr_image(input logic [7:0] cfg);
    logic [7:0] img;
    img            = cfg;
    img[SPCR_EN]   = 1'b1;
    img[SPCR_MSTR] = 1'b1;
    img[SPCR_SPIE] = 1'b0;
    return img;
  endfunction

endpackage

// File: rtl/atmega_spi_burst_fifo.sv
// Synchronous FIFO with full/empty flags and a synchronous flush; head data
// is presented combinationally on data_o.
module atmega_spi_burst_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_r == CW'(DEPTH));
  assign empty_o   = (count_r == {CW{1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/atmega_spi_burst_m.sv
// Burst sequencer driving the register port of an ATmega-style SPI master.
// Optional POLL watchdog: define ATMEGA_SPI_BURST_TIMEOUT_EN.
module atmega_spi_burst_m
  import atmega_spi_pkg::*;
#(
  parameter int unsigned BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned SPCR_ADDR         = 32'h20,
  parameter int unsigned SPSR_ADDR         = 32'h21,
  parameter int unsigned SPDR_ADDR         = 32'h22,
  parameter int unsigned FIFO_DEPTH        = 16
`ifdef ATMEGA_SPI_BURST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [7:0]                   len_i,
  input  logic [7:0]                   cfg_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  input  logic [7:0]                   tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic [7:0]                   rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr_o,
  output logic                         spi_wr_o,
  output logic                         spi_rd_o,
  output logic [7:0]                   spi_bus_o,
  input  logic [7:0]                   spi_bus_i
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPCR = BUS_ADDR_DATA_LEN'(SPCR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPSR = BUS_ADDR_DATA_LEN'(SPSR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_SPDR = BUS_ADDR_DATA_LEN'(SPDR_ADDR);

  state_e     state_r, state_s;
  logic [8:0] rem_r, rem_s;
  logic       busy_r, done_r;
  logic       wr_s, rd_s;
  logic [BUS_ADDR_DATA_LEN-1:0] addr_s;
  logic [7:0] bus_s;
  logic       tx_pop_s, rx_push_s, tx_flush_s;
  logic [7:0] tx_head_s;
  logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;

  atmega_spi_burst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (tx_flush_s),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop_s),
    .data_o  (tx_head_s),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s)
  );

  atmega_spi_burst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (rx_push_s),
    .data_i  (spi_bus_i),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s)
  );

  assign tx_ready_o = ~tx_full_s;
  assign rx_valid_o = ~rx_empty_s;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign spi_wr_o   = wr_s;
  assign spi_rd_o   = rd_s;
  assign spi_addr_o = addr_s;
  assign spi_bus_o  = bus_s;

`ifdef ATMEGA_SPI_BURST_TIMEOUT_EN
  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] tmo_r;
  logic        err_r;
  logic        tmo_hit_s;
  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  // Next-state and register-port access decode, one access per cycle.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    addr_s     = {BUS_ADDR_DATA_LEN{1'b0}};
    bus_s      = 8'h00;
    tx_pop_s   = 1'b0;
    rx_push_s  = 1'b0;
    tx_flush_s = 1'b0;
`ifdef ATMEGA_SPI_BURST_TIMEOUT_EN
    tmo_hit_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_CFG;
          rem_s   = (len_i == 8'd0) ? 9'd256 : {1'b0, len_i};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CFG: begin
        wr_s    = 1'b1;
        addr_s  = A_SPCR;
        bus_s   = spcr_image(cfg_i);
        state_s = ST_CLR;
      end
      ST_CLR: begin
        rd_s    = 1'b1;
        addr_s  = A_SPSR;
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        if (tx_empty_s) begin
          state_s = ST_LOAD;
        end else begin
          wr_s     = 1'b1;
          addr_s   = A_SPDR;
          bus_s    = tx_head_s;
          tx_pop_s = 1'b1;
          state_s  = ST_POLL;
        end
      end
      ST_POLL: begin
        rd_s   = 1'b1;
        addr_s = A_SPSR;
        if (spi_bus_i[SPSR_SPIF]) begin
          state_s = ST_READ;
        end
`ifdef ATMEGA_SPI_BURST_TIMEOUT_EN
        else if (tmo_r == TMO_LAST) begin
          state_s    = ST_DONE;
          tx_flush_s = 1'b1;
          tmo_hit_s  = 1'b1;
        end
`endif
        else begin
          state_s = ST_POLL;
        end
      end
      ST_READ: begin
        // SPDR keeps the received byte, so a full RX FIFO just delays the read.
        if (rx_full_s) begin
          state_s = ST_READ;
        end else begin
          rd_s      = 1'b1;
          addr_s    = A_SPDR;
          rx_push_s = 1'b1;
          rem_s     = rem_r - 9'd1;
          state_s   = (rem_r == 9'd1) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, byte counter and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      rem_r   <= 9'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      busy_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r  <= (state_s == ST_DONE);
    end
  end

`ifdef ATMEGA_SPI_BURST_TIMEOUT_EN
  // POLL watchdog and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_r <= 13'd0;
      err_r <= 1'b0;
    end else begin
      tmo_r <= (state_r == ST_POLL) ? tmo_r + 13'd1 : 13'd0;
      if (state_r == ST_IDLE && start_i) begin
        err_r <= 1'b0;
      end else if (tmo_hit_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`endif

endmodule
